// File: rtl/mbed_ctrl_pkg.sv
// Shared constants for the MBED transfer scheduler: FSM encoding, default
// timing parameters and counter width.
package mbed_ctrl_pkg;

  localparam int CNT_W = 16;

  localparam int SAMPLE_DIV_DEF  = 128;
  localparam int BURST_DEF       = 64;
  localparam int FIN_TIMEOUT_DEF = 4096;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_SEND  = 3'd1;
  localparam logic [2:0] ST_POP   = 3'd2;
  localparam logic [2:0] ST_GAP   = 3'd3;
  localparam logic [2:0] ST_ABORT = 3'd4;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/mbed_xfer_sched_sync_edge.sv
// Two-flop synchroniser with a registered rising-edge pulse; RISE follows
// a rising D by three clocks.
module sync_edge (
  input  logic SYS_CLK,
  input  logic RSTbar,
  input  logic D,
  output logic Q,
  output logic RISE
);

  logic meta_q, sync_q, dly_q, rise_q;
  logic rise_d;

  // Edge detect on the synchronised level only, never on the raw input.
  always_comb begin
    rise_d = sync_q & ~dly_q;
  end

  // Synchroniser chain and edge pulse register.
  always_ff @(posedge SYS_CLK or negedge RSTbar) begin
    if (!RSTbar) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      dly_q  <= 1'b0;
      rise_q <= 1'b0;
    end else begin
      meta_q <= D;
      sync_q <= meta_q;
      dly_q  <= sync_q;
      rise_q <= rise_d;
    end
  end

  assign Q    = sync_q;
  assign RISE = rise_q;

endmodule

// File: rtl/mbed_xfer_sched.sv
// Sample-tick writer and ready-triggered burst drain between the sample FIFO
// and SPI_MASTER_UC. All outputs are registered.
module mbed_xfer_sched
  import mbed_ctrl_pkg::*;
#(
  parameter int SAMPLE_DIV  = SAMPLE_DIV_DEF,
  parameter int BURST       = BURST_DEF,
  parameter int FIN_TIMEOUT = FIN_TIMEOUT_DEF
) (
  input  logic              SYS_CLK,
  input  logic              RSTbar,
  input  logic              SAMPLE_EN,
  input  logic              MBED_RDY_IN,
  input  logic              FIFO_EMPTY,
  input  logic              FIFO_FULL,
  input  logic              SPI_FIN,
  output logic              FIFO_WR,
  output logic              FIFO_RD,
  output logic [CNT_W-1:0]  SAMPLE_CNT,
  output logic              SPI_ENA,
  output logic              SPI_RST,
  output logic              BUSY,
  output logic [CNT_W-1:0]  WORD_CNT,
  output logic [CNT_W-1:0]  OVF_CNT,
  output logic              TIMEOUT
);

  localparam int DIV_W = $clog2(SAMPLE_DIV);
  localparam int TMR_W = $clog2(FIN_TIMEOUT + 1);
  localparam int BST_W = $clog2(BURST + 1);

  logic rdy_s, rdy_rise_s, tick_s;

  logic [DIV_W-1:0] div_q, div_d;
  logic [CNT_W-1:0] sample_cnt_q, sample_cnt_d, ovf_cnt_q, ovf_cnt_d;
  logic [CNT_W-1:0] word_cnt_q, word_cnt_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic [BST_W-1:0] burst_q, burst_d;
  logic [2:0]       state_q, state_d;
  logic fifo_wr_q, fifo_wr_d, fifo_rd_q, fifo_rd_d;
  logic spi_ena_q, spi_ena_d, spi_rst_q, spi_rst_d;
  logic busy_q, busy_d, timeout_q, timeout_d;

  sync_edge u_rdy_sync (
    .SYS_CLK (SYS_CLK),
    .RSTbar  (RSTbar),
    .D       (MBED_RDY_IN),
    .Q       (rdy_s),
    .RISE    (rdy_rise_s)
  );

  // Sample divider, write strobe and counters; the count advances after the write cycle.
  always_comb begin
    tick_s       = SAMPLE_EN && (div_q == DIV_W'(SAMPLE_DIV - 1));
    div_d        = (!SAMPLE_EN || tick_s) ? '0 : div_q + DIV_W'(1);
    fifo_wr_d    = tick_s && !FIFO_FULL;
    sample_cnt_d = fifo_wr_q ? sample_cnt_q + CNT_W'(1) : sample_cnt_q;
    ovf_cnt_d    = (tick_s && FIFO_FULL) ? sat_inc(ovf_cnt_q) : ovf_cnt_q;
  end

  // Burst FSM; outputs are decoded from the next state so they line up with state_q.
  always_comb begin
    state_d    = state_q;
    tmr_d      = tmr_q;
    burst_d    = burst_q;
    word_cnt_d = word_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (rdy_rise_s && !FIFO_EMPTY) begin
          state_d = ST_SEND;
          burst_d = '0;
          tmr_d   = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SEND: begin
        tmr_d = tmr_q + TMR_W'(1);
        if (SPI_FIN) begin
          state_d = ST_POP;
        end else if (tmr_q == TMR_W'(FIN_TIMEOUT - 1)) begin
          state_d = ST_ABORT;
        end else begin
          state_d = ST_SEND;
        end
      end
      ST_POP: begin
        word_cnt_d = word_cnt_q + CNT_W'(1);
        burst_d    = burst_q + BST_W'(1);
        state_d    = ST_GAP;
      end
      ST_GAP: begin
        if ((burst_q < BST_W'(BURST)) && !FIFO_EMPTY && rdy_s) begin
          state_d = ST_SEND;
          tmr_d   = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ABORT: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    spi_ena_d = (state_d == ST_SEND);
    fifo_rd_d = (state_d == ST_POP);
    spi_rst_d = (state_d == ST_ABORT);
    busy_d    = (state_d != ST_IDLE);
    timeout_d = timeout_q || (state_d == ST_ABORT);
  end

  // State and output registers.
  always_ff @(posedge SYS_CLK or negedge RSTbar) begin
    if (!RSTbar) begin
      div_q        <= '0;
      sample_cnt_q <= '0;
      ovf_cnt_q    <= '0;
      word_cnt_q   <= '0;
      tmr_q        <= '0;
      burst_q      <= '0;
      state_q      <= ST_IDLE;
      fifo_wr_q    <= 1'b0;
      fifo_rd_q    <= 1'b0;
      spi_ena_q    <= 1'b0;
      spi_rst_q    <= 1'b0;
      busy_q       <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      div_q        <= div_d;
      sample_cnt_q <= sample_cnt_d;
      ovf_cnt_q    <= ovf_cnt_d;
      word_cnt_q   <= word_cnt_d;
      tmr_q        <= tmr_d;
      burst_q      <= burst_d;
      state_q      <= state_d;
      fifo_wr_q    <= fifo_wr_d;
      fifo_rd_q    <= fifo_rd_d;
      spi_ena_q    <= spi_ena_d;
      spi_rst_q    <= spi_rst_d;
      busy_q       <= busy_d;
      timeout_q    <= timeout_d;
    end
  end

  assign FIFO_WR    = fifo_wr_q;
  assign FIFO_RD    = fifo_rd_q;
  assign SAMPLE_CNT = sample_cnt_q;
  assign SPI_ENA    = spi_ena_q;
  assign SPI_RST    = spi_rst_q;
  assign BUSY       = busy_q;
  assign WORD_CNT   = word_cnt_q;
  assign OVF_CNT    = ovf_cnt_q;
  assign TIMEOUT    = timeout_q;

endmodule

// File: tb/tb_mbed_xfer_sched.sv
// Directed bench for mbed_xfer_sched with a FIFO depth model and an SPI
// master model that answers SPI_ENA with SPI_FIN after fin_delay cycles.
module tb_mbed_xfer_sched;

  typedef struct {
    int words;
    int fin;
    int drop_after;
    int exp_pops;
    int exp_left;
  } burst_vec_t;

  logic clk;
  logic rst_n, sample_en, mbed_rdy, fifo_full, spi_fin;
  logic fifo_empty;
  logic fifo_wr, fifo_rd, spi_ena, spi_rst, busy, timeout;
  logic [15:0] sample_cnt, word_cnt, ovf_cnt;

  int checks = 0;
  int errors = 0;
  int depth_base = 0;
  int wr_n = 0, rd_n = 0, both_n = 0, rst_pulses = 0;
  int rd_empty_viol = 0, overlap_viol = 0;
  int ena_run = 0, last_run = 0, fin_delay = 50, cyc = 0;
  int depth;
  logic [15:0] wr_data[$];
  int wr_cyc[$];

  assign depth      = depth_base + wr_n - rd_n;
  assign fifo_empty = (depth <= 0);

  mbed_xfer_sched #(.SAMPLE_DIV(4), .BURST(4), .FIN_TIMEOUT(100)) dut (
    .SYS_CLK     (clk),
    .RSTbar      (rst_n),
    .SAMPLE_EN   (sample_en),
    .MBED_RDY_IN (mbed_rdy),
    .FIFO_EMPTY  (fifo_empty),
    .FIFO_FULL   (fifo_full),
    .SPI_FIN     (spi_fin),
    .FIFO_WR     (fifo_wr),
    .FIFO_RD     (fifo_rd),
    .SAMPLE_CNT  (sample_cnt),
    .SPI_ENA     (spi_ena),
    .SPI_RST     (spi_rst),
    .BUSY        (busy),
    .WORD_CNT    (word_cnt),
    .OVF_CNT     (ovf_cnt),
    .TIMEOUT     (timeout)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // FIFO and SPI master models, sampled on the falling edge.
  initial begin
    spi_fin = 1'b0;
    forever begin
      @(negedge clk);
      if (fifo_wr) begin
        wr_data.push_back(sample_cnt);
        wr_cyc.push_back(cyc);
      end
      if (fifo_rd) begin
        if (depth <= 0) rd_empty_viol++;
        if (spi_ena) overlap_viol++;
        if (fifo_wr) both_n++;
      end
      if (fifo_wr) wr_n++;
      if (fifo_rd) rd_n++;
      if (spi_rst) rst_pulses++;
      if (spi_ena) begin
        ena_run++;
      end else begin
        if (ena_run > 0) last_run = ena_run;
        ena_run = 0;
      end
      spi_fin = (fin_delay > 0) && spi_ena && (ena_run == fin_delay);
      cyc++;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic set_depth(input int n);
    depth_base = n - wr_n + rd_n;
  endtask

  burst_vec_t vecs[4];
  int w0, r0, s0, wn0, b0, p0, guard, seen, extra;

  initial begin
    vecs[0] = '{words: 10, fin: 50, drop_after: 0, exp_pops: 4, exp_left: 6};
    vecs[1] = '{words: 3,  fin: 50, drop_after: 0, exp_pops: 3, exp_left: 0};
    vecs[2] = '{words: 10, fin: 50, drop_after: 2, exp_pops: 2, exp_left: 8};
    vecs[3] = '{words: 1,  fin: 1,  drop_after: 0, exp_pops: 1, exp_left: 0};

    rst_n = 1'b0; sample_en = 1'b0; mbed_rdy = 1'b0; fifo_full = 1'b0;
    tick(3);
    chk("rst_strobes", {fifo_wr, fifo_rd, spi_ena, spi_rst, busy, timeout}, 0);
    chk("rst_counts", int'(sample_cnt) + int'(word_cnt) + int'(ovf_cnt), 0);
    rst_n = 1'b1;
    tick(3);
    chk("post_rst_idle", {fifo_wr, fifo_rd, spi_ena, busy}, 0);

    // Periodic writes: data 0..19, one write every 4 cycles.
    w0 = wr_data.size(); wn0 = wr_n; guard = 0;
    sample_en = 1'b1;
    while (wr_n < wn0 + 20 && guard < 200) begin tick(1); guard++; end
    sample_en = 1'b0;
    chk("wr_done", int'(guard < 200), 1);
    if (wr_data.size() >= w0 + 20) begin
      for (int i = 0; i < 20; i++) chk($sformatf("wr_data%0d", i), wr_data[w0+i], i);
      for (int i = 1; i < 20; i++) chk($sformatf("wr_gap%0d", i), wr_cyc[w0+i] - wr_cyc[w0+i-1], 4);
    end
    tick(3);
    chk("sample_cnt_after_wr", sample_cnt, 20);
    chk("ovf_none", ovf_cnt, 0);

    // Overflow: 5 ticks with the FIFO full.
    wn0 = wr_n;
    fifo_full = 1'b1; sample_en = 1'b1;
    tick(20);
    sample_en = 1'b0;
    tick(2);
    chk("ovf_cnt", ovf_cnt, 5);
    chk("ovf_no_wr", wr_n - wn0, 0);
    chk("ovf_sample_hold", sample_cnt, 20);
    fifo_full = 1'b0; sample_en = 1'b1; guard = 0; w0 = wr_data.size();
    while (wr_n == wn0 && guard < 20) begin tick(1); guard++; end
    sample_en = 1'b0;
    chk("ovf_release_wr", wr_n - wn0, 1);
    if (wr_data.size() > w0) chk("ovf_release_data", wr_data[w0], 20);
    tick(3);
    chk("ovf_release_cnt", sample_cnt, 21);

    // Burst table.
    for (int v = 0; v < 4; v++) begin
      mbed_rdy = 1'b0; fin_delay = vecs[v].fin; set_depth(vecs[v].words);
      tick(6);
      r0 = rd_n; w0 = int'(word_cnt); seen = 0; guard = 0;
      mbed_rdy = 1'b1;
      while (guard < 3000 && !(seen != 0 && !busy)) begin
        tick(1); guard++;
        if (busy) seen = 1;
        if (vecs[v].drop_after > 0 && rd_n - r0 == vecs[v].drop_after - 1 && spi_ena) mbed_rdy = 1'b0;
      end
      tick(4);
      chk($sformatf("burst%0d_done", v), int'(guard < 3000), 1);
      chk($sformatf("burst%0d_pops", v), rd_n - r0, vecs[v].exp_pops);
      chk($sformatf("burst%0d_left", v), depth, vecs[v].exp_left);
      chk($sformatf("burst%0d_word_cnt", v), int'(word_cnt) - w0, vecs[v].exp_pops);
      chk($sformatf("burst%0d_ena_len", v), last_run, vecs[v].fin);
      chk($sformatf("burst%0d_idle", v), busy, 0);
      chk($sformatf("burst%0d_viol", v), rd_empty_viol + overlap_viol, 0);
    end

    // Collision: second ready edge during SEND ignored; writes and pops coincide.
    mbed_rdy = 1'b0; fin_delay = 49; set_depth(5);
    tick(6);
    r0 = rd_n; w0 = int'(word_cnt); s0 = int'(sample_cnt); wn0 = wr_n; b0 = both_n; guard = 0;
    sample_en = 1'b1; mbed_rdy = 1'b1;
    while (!spi_ena && guard < 20) begin tick(1); guard++; end
    chk("coll_send", spi_ena, 1);
    tick(5); mbed_rdy = 1'b0;
    tick(5); mbed_rdy = 1'b1;
    guard = 0;
    while (busy && guard < 1000) begin tick(1); guard++; end
    sample_en = 1'b0;
    extra = 0;
    for (int i = 0; i < 20; i++) begin tick(1); if (busy) extra++; end
    chk("coll_pops", rd_n - r0, 4);
    chk("coll_no_restart", extra, 0);
    chk("coll_same_cycle", int'(both_n > b0), 1);
    chk("coll_sample_adv", int'(sample_cnt) - s0, wr_n - wn0);
    chk("coll_word_cnt", int'(word_cnt) - w0, 4);

    // Timeout: SPI never finishes.
    mbed_rdy = 1'b0; fin_delay = 0; set_depth(3);
    tick(6);
    p0 = rst_pulses; w0 = int'(word_cnt); guard = 0;
    mbed_rdy = 1'b1;
    while (rst_pulses == p0 && guard < 500) begin tick(1); guard++; end
    tick(3);
    chk("to_ena_len", last_run, 100);
    chk("to_rst_pulse", rst_pulses - p0, 1);
    chk("to_sticky", timeout, 1);
    chk("to_word_cnt", int'(word_cnt) - w0, 0);
    chk("to_depth", depth, 3);
    chk("to_idle", busy, 0);

    // Asynchronous reset mid-SEND.
    mbed_rdy = 1'b0; fin_delay = 50; set_depth(2);
    tick(6);
    mbed_rdy = 1'b1; guard = 0;
    while (!spi_ena && guard < 20) begin tick(1); guard++; end
    chk("arst_in_send", spi_ena, 1);
    tick(5);
    rst_n = 1'b0;
    #1;
    chk("arst_strobes", {fifo_wr, fifo_rd, spi_ena, spi_rst, busy, timeout}, 0);
    chk("arst_counts", int'(sample_cnt) + int'(word_cnt) + int'(ovf_cnt), 0);
    tick(2);
    rst_n = 1'b1; mbed_rdy = 1'b0;
    tick(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
